// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan controller.
// Segment patterns are active-low {a,b,c,d,e,f,g}.
package seg7_scan_ctrl_pkg;

  localparam logic [6:0] SEG_0   = 7'b0000001;
  localparam logic [6:0] SEG_1   = 7'b1001111;
  localparam logic [6:0] SEG_2   = 7'b0010010;
  localparam logic [6:0] SEG_3   = 7'b0000110;
  localparam logic [6:0] SEG_4   = 7'b1001100;
  localparam logic [6:0] SEG_5   = 7'b0100100;
  localparam logic [6:0] SEG_6   = 7'b0100000;
  localparam logic [6:0] SEG_7   = 7'b0001111;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0000100;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b1100000;
  localparam logic [6:0] SEG_C   = 7'b0110001;
  localparam logic [6:0] SEG_D   = 7'b1000010;
  localparam logic [6:0] SEG_E   = 7'b0110000;
  localparam logic [6:0] SEG_F   = 7'b0111000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StShow
  } scan_state_e;

  // True when digit k (1..3) and every digit above it are zero; digit 0 is never blanked.
  function automatic logic lead_zero(input logic [15:0] v, input logic [1:0] k);
    case (k)
      2'd1:    return v[15:4] == 12'h000;
      2'd2:    return v[15:8] == 8'h00;
      2'd3:    return v[15:12] == 4'h0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern decoder.
module seg7_hex_decoder
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment scanner with dead-time blanking, leading-zero
// suppression and frame-aligned value commit.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        blank_lead,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam scan_state_e SlotStart = (BLANK_CYCLES == 0) ? StShow : StBlank;

  scan_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     pend_val_q, pend_val_d, comm_val_q, comm_val_d;
  logic [3:0]      pend_dp_q, pend_dp_d, comm_dp_q, comm_dp_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      dec_seg;
  logic            commit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        idx_d = '0;
        if (enable) state_d = SlotStart;
      end
      StBlank: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == BlankLast) state_d = StShow;
      end
      StShow: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
          state_d = SlotStart;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!enable) begin
      state_d = StIdle;
      cnt_d   = '0;
      idx_d   = '0;
    end
  end

  assign frame_tick = (state_q == StShow) && (idx_q == 2'd3) && (cnt_q == CntLast);

  // A load coinciding with the commit point bypasses pending so it is not lost for a frame.
  assign commit     = (state_q == StIdle) || frame_tick;
  assign pend_val_d = load ? value : pend_val_q;
  assign pend_dp_d  = load ? dp_in : pend_dp_q;
  assign comm_val_d = commit ? pend_val_d : comm_val_q;
  assign comm_dp_d  = commit ? pend_dp_d : comm_dp_q;

  seg7_hex_decoder u_dec (
    .nibble (comm_val_q[{idx_q, 2'b00} +: 4]),
    .seg    (dec_seg)
  );

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_q == StShow) begin
      an_d[idx_q] = 1'b0;
      seg_d       = (blank_lead && lead_zero(comm_val_q, idx_q)) ? SEG_OFF : dec_seg;
      dp_d        = ~comm_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      comm_val_q <= '0;
      comm_dp_q  <= '0;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
      an_q       <= AN_OFF;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      comm_val_q <= comm_val_d;
      comm_dp_q  <= comm_dp_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule
